// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e        : hazard FSM state encoding
//   - legal ranges   : LOAD_STALL_CYCLES and MULDIV_LAT bounds
//   - counter widths : sized so the largest legal reload value fits
//   - clampInt       : pins a parameter into its legal range at elaboration
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MULDIV    = 2'd2
  } state_e;

  localparam int LOAD_STALL_MIN = 1;
  localparam int LOAD_STALL_MAX = 4;
  localparam int MULDIV_LAT_MIN = 2;
  localparam int MULDIV_LAT_MAX = 32;

  // Reload values are (limit - 1), so $clog2(limit) bits are enough.
  localparam int LOAD_CNT_W = $clog2(LOAD_STALL_MAX);
  localparam int BUSY_CNT_W = $clog2(MULDIV_LAT_MAX);

  // Out-of-range parameters are pulled to the nearest legal value so the
  // counters can never be loaded with something they cannot hold.
  function automatic int clampInt(input int value, input int lo, input int hi);
    if (value < lo) begin
      return lo;
    end
    if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Free-running up-counter that sticks at its all-ones value.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high clear
//   inc   in  1  add one at the next edge (ignored once saturated)
//   count out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard unit: load-use bubbles, multi-cycle mul/div occupancy of
// EX, and taken-branch squashing, plus a saturating stall-cycle counter.
// Ports:
//   clk, rst                    clock / synchronous active-high reset
//   id_rs1, id_rs2              IF/ID source register indices
//   id_rs1_used, id_rs2_used    source actually read by the ID instruction
//   ex_rd                       ID/EX destination index
//   ex_mem_read                 ID/EX instruction is a load
//   ex_muldiv                   ID/EX instruction is a mul/div op
//   ex_branch_taken             redirect resolved in EX this cycle
//   stall_if, stall_id          hold PC and IF/ID
//   bubble_ex                   load a NOP into ID/EX next edge
//   flush_id                    squash IF/ID next edge
//   stall_ex                    hold ID/EX, inject NOP into EX/MEM
//   muldiv_busy                 FSM is in the MULDIV state
//   stall_count                 saturating count of stall_if cycles
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MULDIV_LAT        = 4,
  parameter int CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_muldiv,
  input  logic                  ex_branch_taken,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  stall_ex,
  output logic                  muldiv_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int LoadStalls =
    clampInt(LOAD_STALL_CYCLES, LOAD_STALL_MIN, LOAD_STALL_MAX);
  localparam int MulDivLat =
    clampInt(MULDIV_LAT, MULDIV_LAT_MIN, MULDIV_LAT_MAX);

  // The cycle that detects the hazard already counts as the first stall,
  // so the wait counters are loaded with one less than the total.
  localparam logic [LOAD_CNT_W-1:0] LoadReload = LOAD_CNT_W'(LoadStalls - 1);
  localparam logic [BUSY_CNT_W-1:0] BusyReload = BUSY_CNT_W'(MulDivLat - 1);

  state_e                 state_q;
  state_e                 state_d;
  logic [LOAD_CNT_W-1:0]  loadCnt_q;
  logic [LOAD_CNT_W-1:0]  loadCnt_d;
  logic [BUSY_CNT_W-1:0]  busyCnt_q;
  logic [BUSY_CNT_W-1:0]  busyCnt_d;

  logic                   loadUseHit;
  logic                   stallFront;
  logic                   bubbleEx;
  logic                   flushId;
  logic                   stallEx;
  logic [CNT_W-1:0]       stallCountRaw;

  // Register x0 is hard-wired to zero, so it can never carry a dependency.
  always_comb begin
    loadUseHit = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      loadCnt_q <= '0;
      busyCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      loadCnt_q <= loadCnt_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  // A taken branch wins in IDLE: the younger instructions it would stall
  // are being squashed anyway. Outside IDLE the pipeline cannot present a
  // taken branch, so the input is not looked at there.
  always_comb begin
    state_d    = state_q;
    loadCnt_d  = loadCnt_q;
    busyCnt_d  = busyCnt_q;
    stallFront = 1'b0;
    bubbleEx   = 1'b0;
    flushId    = 1'b0;
    stallEx    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_branch_taken) begin
          flushId  = 1'b1;
          bubbleEx = 1'b1;
        end else if (loadUseHit) begin
          stallFront = 1'b1;
          bubbleEx   = 1'b1;
          if (LoadStalls > 1) begin
            loadCnt_d = LoadReload;
            state_d   = ST_LOAD_WAIT;
          end
        end else if (ex_muldiv) begin
          stallFront = 1'b1;
          stallEx    = 1'b1;
          busyCnt_d  = BusyReload;
          state_d    = ST_MULDIV;
        end
      end

      ST_LOAD_WAIT: begin
        stallFront = 1'b1;
        bubbleEx   = 1'b1;
        loadCnt_d  = loadCnt_q - LOAD_CNT_W'(1);
        if (loadCnt_q <= LOAD_CNT_W'(1)) begin
          loadCnt_d = '0;
          state_d   = ST_IDLE;
        end
      end

      // On the final count the result is ready, so the stalls drop in the
      // same cycle and the op moves on to EX/MEM at the coming edge.
      ST_MULDIV: begin
        busyCnt_d = busyCnt_q - BUSY_CNT_W'(1);
        if (busyCnt_q <= BUSY_CNT_W'(1)) begin
          busyCnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          stallFront = 1'b1;
          stallEx    = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        loadCnt_d = '0;
        busyCnt_d = '0;
      end
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if),
    .count (stallCountRaw)
  );

  // Everything is forced low while reset is held, including the registered
  // outputs, so nothing leaks out before the first reset edge clears state.
  assign stall_if    = !rst && stallFront;
  assign stall_id    = !rst && stallFront;
  assign bubble_ex   = !rst && bubbleEx;
  assign flush_id    = !rst && flushId;
  assign stall_ex    = !rst && stallEx;
  assign muldiv_busy = !rst && (state_q == ST_MULDIV);
  assign stall_count = rst ? '0 : stallCountRaw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives two hazard_ctrl instances from the same inputs:
//   A : LOAD_STALL_CYCLES=1, MULDIV_LAT=4, CNT_W=32
//   B : LOAD_STALL_CYCLES=3, MULDIV_LAT=6, CNT_W=3
// Each instance is tracked by a cycle-level model that counts owed bubbles
// and the position inside a mul/div op; directed sequences add explicit
// expected constants for the corner cases.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int AW    = 5;
  localparam int A_LSC = 1;
  localparam int A_LAT = 4;
  localparam int A_CW  = 32;
  localparam int B_LSC = 3;
  localparam int B_LAT = 6;
  localparam int B_CW  = 3;

  typedef struct {
    logic          r;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          mr;
    logic          md;
    logic          br;
  } in_t;

  typedef struct {
    int     loadOwed;
    int     mdCycle;
    longint cnt;
  } mdl_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [2:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] idRs1 = '0;
  logic [AW-1:0] idRs2 = '0;
  logic idRs1Used = 1'b0;
  logic idRs2Used = 1'b0;
  logic [AW-1:0] exRd = '0;
  logic exMemRead = 1'b0;
  logic exMulDiv = 1'b0;
  logic exBranch = 1'b0;

  logic aStallIf, aStallId, aBubble, aFlush, aStallEx, aBusy;
  logic [A_CW-1:0] aCount;
  logic bStallIf, bStallId, bBubble, bFlush, bStallEx, bBusy;
  logic [B_CW-1:0] bCount;

  in_t  cur;
  mdl_t mA;
  mdl_t mB;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W(AW), .LOAD_STALL_CYCLES(A_LSC), .MULDIV_LAT(A_LAT), .CNT_W(A_CW)
  ) dutA (
    .clk(clk), .rst(rst),
    .id_rs1(idRs1), .id_rs2(idRs2),
    .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
    .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_muldiv(exMulDiv),
    .ex_branch_taken(exBranch),
    .stall_if(aStallIf), .stall_id(aStallId), .bubble_ex(aBubble),
    .flush_id(aFlush), .stall_ex(aStallEx), .muldiv_busy(aBusy),
    .stall_count(aCount)
  );

  hazard_ctrl #(
    .REG_ADDR_W(AW), .LOAD_STALL_CYCLES(B_LSC), .MULDIV_LAT(B_LAT), .CNT_W(B_CW)
  ) dutB (
    .clk(clk), .rst(rst),
    .id_rs1(idRs1), .id_rs2(idRs2),
    .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
    .ex_rd(exRd), .ex_mem_read(exMemRead), .ex_muldiv(exMulDiv),
    .ex_branch_taken(exBranch),
    .stall_if(bStallIf), .stall_id(bStallId), .bubble_ex(bBubble),
    .flush_id(bFlush), .stall_ex(bStallEx), .muldiv_busy(bBusy),
    .stall_count(bCount)
  );

  function automatic in_t mk(input logic r, input int rs1, input logic u1,
                             input int rs2, input logic u2, input int rd,
                             input logic mr, input logic md, input logic br);
    in_t v;
    v.r = r;   v.rs1 = AW'(rs1); v.u1 = u1; v.rs2 = AW'(rs2); v.u2 = u2;
    v.rd = AW'(rd); v.mr = mr; v.md = md; v.br = br;
    return v;
  endfunction

  function automatic logic hitOf(input in_t v);
    return v.mr && (v.rd != 0) &&
           ((v.u1 && (v.rs1 == v.rd)) || (v.u2 && (v.rs2 == v.rd)));
  endfunction

  // Expected outputs as {stall_if, stall_id, bubble_ex, flush_id, stall_ex, muldiv_busy}.
  function automatic logic [5:0] modelOut(input mdl_t m, input int lat, input in_t v);
    logic [5:0] o;
    o = 6'b000000;
    if (v.r) begin
      o = 6'b000000;
    end else if (m.loadOwed > 0) begin
      o = 6'b111000;
    end else if (m.mdCycle > 0) begin
      o = 6'b000001;
      if (m.mdCycle < lat) o = o | 6'b110010;
    end else if (v.br) begin
      o = 6'b001100;
    end else if (hitOf(v)) begin
      o = 6'b111000;
    end else if (v.md) begin
      o = 6'b110010;
    end
    return o;
  endfunction

  function automatic mdl_t modelNext(input mdl_t m, input int lsc, input int lat,
                                     input int cw, input in_t v);
    mdl_t       n;
    logic [5:0] o;
    longint     cmax;
    n = m;
    if (v.r) begin
      n.loadOwed = 0; n.mdCycle = 0; n.cnt = 0;
      return n;
    end
    o    = modelOut(m, lat, v);
    cmax = (longint'(1) << cw) - 1;
    if (o[5] && (n.cnt < cmax)) n.cnt = n.cnt + 1;
    if (m.loadOwed > 0) begin
      n.loadOwed = m.loadOwed - 1;
    end else if (m.mdCycle > 0) begin
      n.mdCycle = (m.mdCycle >= lat) ? 0 : m.mdCycle + 1;
    end else if (!v.br) begin
      if (hitOf(v))  n.loadOwed = lsc - 1;
      else if (v.md) n.mdCycle  = 2;
    end
    return n;
  endfunction

  task automatic checkVal(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well clear of either edge.
  task automatic applyStimulus(input in_t v);
    @(posedge clk);
    #1;
    cur       = v;
    rst       = v.r;
    idRs1     = v.rs1;
    idRs2     = v.rs2;
    idRs1Used = v.u1;
    idRs2Used = v.u2;
    exRd      = v.rd;
    exMemRead = v.mr;
    exMulDiv  = v.md;
    exBranch  = v.br;
    #2;
  endtask

  task automatic checkOutput();
    checkVal("A_outputs", longint'({aStallIf, aStallId, aBubble, aFlush, aStallEx, aBusy}),
             longint'(modelOut(mA, A_LAT, cur)));
    checkVal("A_stall_count", longint'(aCount), cur.r ? 0 : mA.cnt);
    checkVal("B_outputs", longint'({bStallIf, bStallId, bBubble, bFlush, bStallEx, bBusy}),
             longint'(modelOut(mB, B_LAT, cur)));
    checkVal("B_stall_count", longint'(bCount), cur.r ? 0 : mB.cnt);
    mA = modelNext(mA, A_LSC, A_LAT, A_CW, cur);
    mB = modelNext(mB, B_LSC, B_LAT, B_CW, cur);
  endtask

  task automatic step(input in_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    vec_t       vecs[10];
    in_t        idle;
    in_t        resetVec;
    in_t        hit5;
    logic [3:0] expA;
    logic [3:0] expB;
    logic [3:0] expEx;
    logic [3:0] expBusy;

    idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetVec = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    hit5     = mk(0, 5, 1, 0, 0, 5, 1, 0, 0);
    mA = '{0, 0, 0};
    mB = '{0, 0, 0};
    cur = resetVec;

    vecs[0] = '{"hit_rs1",        mk(0, 5, 1, 0, 0, 5, 1, 0, 0),   3'b110};
    vecs[1] = '{"hit_rs2",        mk(0, 3, 1, 7, 1, 7, 1, 0, 0),   3'b110};
    vecs[2] = '{"rs1_unused",     mk(0, 5, 0, 0, 0, 5, 1, 0, 0),   3'b000};
    vecs[3] = '{"not_a_load",     mk(0, 5, 1, 5, 1, 5, 0, 0, 0),   3'b000};
    vecs[4] = '{"rd_zero",        mk(0, 0, 1, 0, 1, 0, 1, 0, 0),   3'b000};
    vecs[5] = '{"index_differs",  mk(0, 4, 1, 6, 1, 5, 1, 0, 0),   3'b000};
    vecs[6] = '{"branch_only",    mk(0, 0, 0, 0, 0, 0, 0, 0, 1),   3'b011};
    vecs[7] = '{"branch_and_hit", mk(0, 9, 1, 0, 0, 9, 1, 0, 1),   3'b011};
    vecs[8] = '{"quiet",          idle,                            3'b000};
    vecs[9] = '{"hit_index_31",   mk(0, 0, 0, 31, 1, 31, 1, 0, 0), 3'b110};

    // Reset: everything low.
    step(resetVec);
    step(resetVec);
    checkVal("reset_A_stall_if", longint'(aStallIf), 0);
    checkVal("reset_A_count", longint'(aCount), 0);

    // Load-use hit followed by quiet cycles: A bubbles once, B three times.
    expA = 4'b0001;
    expB = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? hit5 : idle);
      checkVal($sformatf("load_A_stall_c%0d", i), longint'(aStallIf), longint'(expA[i]));
      checkVal($sformatf("load_B_bubble_c%0d", i), longint'(bBubble), longint'(expB[i]));
    end
    checkVal("load_A_count", longint'(aCount), 1);
    checkVal("load_B_count", longint'(bCount), 3);
    step(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
    checkVal("rd0_A_stall", longint'(aStallIf), 0);
    checkVal("rd0_B_stall", longint'(bStallIf), 0);

    // Mul/div held in EX for four cycles, then released.
    step(resetVec);
    expEx   = 4'b0111;
    expBusy = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      checkVal($sformatf("md_A_stall_ex_c%0d", i + 1), longint'(aStallEx), longint'(expEx[i]));
      checkVal($sformatf("md_A_busy_c%0d", i + 1), longint'(aBusy), longint'(expBusy[i]));
    end
    step(idle);
    checkVal("md_A_done_stall_ex", longint'(aStallEx), 0);
    checkVal("md_A_done_busy", longint'(aBusy), 0);

    // Taken branch beats a simultaneous load-use hit; FSM stays in IDLE.
    step(resetVec);
    step(mk(0, 5, 1, 0, 0, 5, 1, 0, 1));
    checkVal("br_A_flush", longint'(aFlush), 1);
    checkVal("br_A_bubble", longint'(aBubble), 1);
    checkVal("br_A_stall_if", longint'(aStallIf), 0);
    step(idle);
    checkVal("br_B_stays_idle", longint'(bStallIf), 0);

    // Reset in the second cycle of a mul/div op.
    step(resetVec);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    checkVal("rstmd_A_outputs_in_rst",
             longint'({aStallIf, aStallId, aBubble, aFlush, aStallEx, aBusy}), 0);
    step(idle);
    checkVal("rstmd_A_outputs",
             longint'({aStallIf, aStallId, aBubble, aFlush, aStallEx, aBusy}), 0);
    checkVal("rstmd_A_count", longint'(aCount), 0);

    // Ten consecutive stall cycles: B's 3-bit counter saturates at 7.
    step(resetVec);
    for (int i = 0; i < 10; i++) step(hit5);
    step(idle);
    checkVal("sat_B_count", longint'(bCount), 7);
    checkVal("sat_A_count", longint'(aCount), 10);

    // Single-cycle decode table, checked against instance A from IDLE.
    step(resetVec);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].in);
      checkVal({"tbl_", vecs[i].name}, longint'({aStallIf, aBubble, aFlush}),
               longint'(vecs[i].exp));
    end

    // Random traffic over a small register space to provoke many matches.
    for (int i = 0; i < 600; i++) begin
      in_t v;
      int  sel;
      sel = int'($urandom_range(0, 3));
      v.r   = ($urandom_range(0, 49) == 0);
      v.rs1 = AW'($urandom_range(0, 3));
      v.rs2 = AW'($urandom_range(0, 3));
      v.rd  = AW'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.mr  = (sel == 1);
      v.md  = (sel == 2);
      v.br  = ($urandom_range(0, 9) == 0);
      step(v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
